// File: rtl/rgb_led_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : led_pkg                                                 |
// | Brief   : Shared types and constants for the RGB LED arbiter.     |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package led_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic LED_OFF = 1'b1;

    localparam int R_IDX = 2;
    localparam int G_IDX = 1;
    localparam int B_IDX = 0;

endpackage
`default_nettype wire

// File: rtl/rgb_led_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rgb_led_arbiter_if                                      |
// | Brief   : Request/display bundle between status sources and LED.  |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
interface rgb_led_arbiter_if #(
    parameter int N_REQ    = 3,
    parameter int PWM_BITS = 8
);
    logic [N_REQ-1:0]          req;
    logic [3*N_REQ-1:0]        color;
    logic [PWM_BITS*N_REQ-1:0] level;
    logic [N_REQ-1:0]          grant;
    logic                      busy;
    logic                      led_r;
    logic                      led_g;
    logic                      led_b;

    modport master (
        output req, color, level,
        input  grant, busy, led_r, led_g, led_b
    );

    modport slave (
        input  req, color, level,
        output grant, busy, led_r, led_g, led_b
    );
endinterface
`default_nettype wire

// File: rtl/rgb_led_arbiter_pwm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : led_pwm                                                 |
// | Brief   : Free-running PWM with registered active-low RGB pins.   |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module led_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [2:0]          i_latched_color,
    input  wire logic [PWM_BITS-1:0] i_latched_level,
    output logic                     o_led_r,
    output logic                     o_led_g,
    output logic                     o_led_b
);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [2:0]          w_on;

    // Strict less-than makes level 0 fully dark and max level one slot short of full.
    assign w_on = i_latched_color & {3{r_pwm_cnt < i_latched_level}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            o_led_r   <= LED_OFF;
            o_led_g   <= LED_OFF;
            o_led_b   <= LED_OFF;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            o_led_r   <= w_on[R_IDX] ? ~LED_OFF : LED_OFF;
            o_led_g   <= w_on[G_IDX] ? ~LED_OFF : LED_OFF;
            o_led_b   <= w_on[B_IDX] ? ~LED_OFF : LED_OFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rgb_led_arbiter                                         |
// | Brief   : Fixed-priority LED owner with minimum hold and PWM.     |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module rgb_led_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 2500000,
    parameter int PWM_BITS    = 8
) (
    input  wire logic       clk_25m,
    input  wire logic       rst,
    rgb_led_arbiter_if.slave bus
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] c_hold_reload = HOLD_W'(HOLD_CYCLES - 1);

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic                r_busy;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [2:0]          r_latched_color;
    logic [PWM_BITS-1:0] r_latched_level;

    logic [N_REQ-1:0]    w_req;
    logic [N_REQ-1:0]    w_req_lowest;
    logic                w_any_req;
    logic                w_higher_req;
    logic                w_owner_req;
    logic                w_switch;
    logic                w_release;
    logic [N_REQ-1:0]    w_sel;
    logic [2:0]          w_sel_color;
    logic [PWM_BITS-1:0] w_sel_level;

    assign w_req        = bus.req;
    // Isolate the lowest set bit: it is the winner whether it is above or below the owner.
    assign w_req_lowest = w_req & (~w_req + N_REQ'(1));
    assign w_any_req    = |w_req;
    assign w_higher_req = |(w_req & (r_grant - N_REQ'(1)));
    assign w_owner_req  = |(w_req & r_grant);

    always_comb begin
        w_switch  = 1'b0;
        w_release = 1'b0;
        if (r_state == IDLE) begin
            w_switch = w_any_req;
        end else if (r_hold_cnt == '0) begin
            w_switch  = w_higher_req || (!w_owner_req && w_any_req);
            w_release = !w_any_req;
        end
    end

    assign w_sel = w_switch ? w_req_lowest : r_grant;

    always_comb begin
        w_sel_color = '0;
        w_sel_level = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) begin
                w_sel_color = w_sel_color | bus.color[3*i +: 3];
                w_sel_level = w_sel_level | bus.level[PWM_BITS*i +: PWM_BITS];
            end
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_busy          <= 1'b0;
            r_hold_cnt      <= '0;
            r_latched_color <= '0;
            r_latched_level <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_switch) begin
                        r_state    <= OWNED;
                        r_grant    <= w_req_lowest;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= c_hold_reload;
                    end
                end
                OWNED: begin
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end else if (w_switch) begin
                        r_grant    <= w_req_lowest;
                        r_hold_cnt <= c_hold_reload;
                    end else if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Clearing on release keeps the pins dark in IDLE without a separate gate.
            if (w_release) begin
                r_latched_color <= '0;
                r_latched_level <= '0;
            end else if (w_switch || w_owner_req) begin
                r_latched_color <= w_sel_color;
                r_latched_level <= w_sel_level;
            end
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_led_pwm (
        .clk             (clk_25m),
        .rst             (rst),
        .i_latched_color (r_latched_color),
        .i_latched_level (r_latched_level),
        .o_led_r         (bus.led_r),
        .o_led_g         (bus.led_g),
        .o_led_b         (bus.led_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_rgb_led_arbiter                                      |
// | Brief   : Directed + random bench with behavioural owner model.   |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_rgb_led_arbiter;

    localparam int N    = 3;
    localparam int HOLD = 8;
    localparam int PB   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    rgb_led_arbiter_if #(.N_REQ(N), .PWM_BITS(PB)) bus ();

    rgb_led_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (HOLD),
        .PWM_BITS    (PB)
    ) dut (
        .clk_25m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the LED, how many edges since the grant, what is on display.
    int          m_owner = -1;
    int          m_age   = 0;
    logic [2:0]  m_col   = '0;
    logic [PB-1:0] m_lvl = '0;
    logic [PB-1:0] m_cnt = '0;
    logic [2:0]  m_pins  = 3'b111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int   first;
        int   nxt;
        bit   sw;
        logic [N-1:0] exp_grant;
        @(posedge clk);
        if (rst) m_pins = 3'b111;
        else for (int c = 0; c < 3; c++) m_pins[c] = ~(m_col[c] & (m_cnt < m_lvl));
        first = -1;
        for (int i = N-1; i >= 0; i--) if (bus.req[i]) first = i;
        if (rst) begin
            m_owner = -1; m_age = 0; m_col = '0; m_lvl = '0; m_cnt = '0;
        end else begin
            m_cnt = m_cnt + 1'b1;
            nxt = m_owner;
            sw  = 1'b0;
            if (m_owner < 0) begin
                if (first >= 0) begin nxt = first; sw = 1'b1; end
            end else if (m_age < HOLD-1) begin
                m_age++;
            end else if (first >= 0 && first < m_owner) begin
                nxt = first; sw = 1'b1;
            end else if (bus.req[m_owner]) begin
                nxt = m_owner;
            end else if (first >= 0) begin
                nxt = first; sw = 1'b1;
            end else begin
                nxt = -1;
            end
            if (sw) m_age = 0;
            if (nxt < 0) begin
                m_col = '0; m_lvl = '0; m_age = 0;
            end else if (sw || bus.req[nxt]) begin
                m_col = bus.color[3*nxt +: 3];
                m_lvl = bus.level[PB*nxt +: PB];
            end
            m_owner = nxt;
        end
        exp_grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
        #1;
        chk("grant",  32'(bus.grant), 32'(exp_grant));
        chk("busy",   32'(bus.busy),  32'(m_owner >= 0));
        chk("leds",   32'({bus.led_r, bus.led_g, bus.led_b}), 32'(m_pins));
        chk("onehot", 32'($onehot0(bus.grant)), 32'(1));
    endtask

    task automatic go_idle();
        bus.req = '0;
        repeat (12) cycle();
    endtask

    initial begin
        int n;
        int lows;
        bus.req   = 3'b111;
        bus.color = '0;
        bus.level = '0;

        // Reset held three cycles with every requester asking.
        repeat (3) begin
            cycle();
            chk("rst_grant", 32'(bus.grant), 32'(0));
        end
        rst = 1'b0;
        cycle();
        chk("first_grant", 32'(bus.grant), 32'(3'b001));
        go_idle();

        // Priority in IDLE, red at level 255.
        bus.color = {3'b001, 3'b100, 3'b000};
        bus.level = {8'd10, 8'd255, 8'd0};
        bus.req   = 3'b110;
        cycle();
        chk("prio_grant", 32'(bus.grant), 32'(3'b010));
        cycle();
        lows = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (bus.led_r == 1'b0) lows++;
        end
        chk("red_duty", 32'(lows), 32'(255));
        go_idle();

        // Hold window blocks a higher-priority request.
        bus.req = 3'b100;
        cycle();
        chk("hold_start", 32'(bus.grant), 32'(3'b100));
        bus.req = 3'b101;
        n = 1;
        while (bus.grant == 3'b100 && n < 20) begin
            cycle();
            if (bus.grant == 3'b100) n++;
        end
        chk("hold_len", 32'(n), 32'(HOLD));
        chk("hold_next", 32'(bus.grant), 32'(3'b001));
        go_idle();

        // Single-cycle pulse still shown for the full hold.
        bus.color = {3'b000, 3'b010, 3'b000};
        bus.level = {8'd0, 8'd128, 8'd0};
        bus.req   = 3'b010;
        cycle();
        bus.req = 3'b000;
        n = 1;
        while (bus.grant == 3'b010 && n < 20) begin
            cycle();
            if (bus.grant == 3'b010) n++;
        end
        chk("pulse_len", 32'(n), 32'(HOLD));
        chk("pulse_idle", 32'(bus.grant), 32'(0));
        cycle();
        chk("pulse_dark", 32'({bus.led_r, bus.led_g, bus.led_b}), 32'(3'b111));
        go_idle();

        // Owner 0 releases after expiry, requester 2 takes over at once.
        bus.req = 3'b101;
        cycle();
        chk("fall_own0", 32'(bus.grant), 32'(3'b001));
        repeat (10) cycle();
        bus.req = 3'b100;
        cycle();
        chk("fall_grant", 32'(bus.grant), 32'(3'b100));
        chk("fall_reload", 32'(dut.r_hold_cnt), 32'(HOLD-1));
        go_idle();

        // Reset in the middle of a hold.
        bus.req = 3'b010;
        cycle();
        repeat (3) cycle();
        chk("mid_cnt", 32'(dut.r_hold_cnt), 32'(4));
        rst = 1'b1;
        cycle();
        chk("mid_rst_cnt", 32'(dut.r_hold_cnt), 32'(0));
        chk("mid_rst_leds", 32'({bus.led_r, bus.led_g, bus.led_b}), 32'(3'b111));
        rst = 1'b0;
        go_idle();

        // Level 0 owner never lights anything.
        bus.color = {3'b000, 3'b000, 3'b111};
        bus.level = '0;
        bus.req   = 3'b001;
        n = 0;
        for (int k = 0; k < 260; k++) begin
            cycle();
            if ({bus.led_r, bus.led_g, bus.led_b} != 3'b111) n++;
        end
        chk("level0_dark", 32'(n), 32'(0));
        go_idle();

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.req   = N'($urandom_range(0, 7));
                bus.color = 9'($urandom);
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 3))
                        0:       bus.level[PB*i +: PB] = '0;
                        1:       bus.level[PB*i +: PB] = '1;
                        default: bus.level[PB*i +: PB] = PB'($urandom);
                    endcase
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

- Shares the board's single RGB status LED among `N_REQ` requesters: heartbeat, audio-activity, FFT-overflow, error.
- Grants the LED by fixed priority and enforces a minimum display (hold) time so short events stay visible.
- Drives active-low `led_r`/`led_g`/`led_b` through an 8-bit PWM brightness stage.
- Sits between the status sources in `top` and the LED pins, replacing per-project ad-hoc LED muxing.

## Interface
- `N_REQ`, default 3: number of requesters; index 0 has the highest priority.
- `HOLD_CYCLES`, default 2500000: minimum display time after a grant (100 ms at 25 MHz); must be ≥ 2.
- `PWM_BITS`, default 8: brightness resolution.
- `clk_25m`, in, 1: system clock, 25 MHz. One clock domain only.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, `N_REQ`: request, level-sensitive, one bit per requester.
- `color`, in, `3*N_REQ`: per-requester `{r,g,b}`. Requester i uses bits `[3i+2:3i]`.
- `level`, in, `PWM_BITS*N_REQ`: per-requester brightness.
- `grant`, out, `N_REQ`: one-hot current owner, or all zero.
- `busy`, out, 1: high while any owner holds the LED.
- `led_r`, `led_g`, `led_b`, out, 1 each: active-low LED drives.

## Operation
- **FSM states:** IDLE and OWNED.
- **IDLE**
  - `grant`=0, `busy`=0, LEDs off (1).
  - Any `req` bit set → grant the lowest set index.
  - Load `hold_cnt` = `HOLD_CYCLES`-1, go to OWNED.
- **Display latches in OWNED**
  - While the owner's `req` is high, its `color`/`level` are copied into display latches every cycle.
  - If the owner's `req` drops, the latches freeze.
- **OWNED, `hold_cnt` > 0**
  - Decrement each cycle.
  - No preemption, even by a higher-priority requester, and even if the owner drops `req`.
- **OWNED, `hold_cnt` == 0 (arbitration every cycle)**
  - Higher-priority `req` set → switch `grant` to it and reload `hold_cnt`.
  - Else owner `req` high → keep the grant and leave `hold_cnt` at 0, so it stays preemptible.
  - Else lower-priority `req` set → switch to the highest of those and reload.
  - Else → IDLE.
- **PWM**
  - `pwm_cnt` is `PWM_BITS` wide, free-running from reset, wrapping 2^`PWM_BITS`-1 → 0.
  - Channel c is on when `latched_color[c]` and `pwm_cnt` < `latched_level`.
  - Duty = `level`/2^`PWM_BITS`. `level`=0 is always off; `level`=255 is on 255/256.
  - The LED pin is the registered inverse of channel-on.
- **Reset**
  - Resets everything regardless of state or mid-hold.
  - `grant`=0, `busy`=0, `hold_cnt`=0, `pwm_cnt`=0, latches=0, LEDs=1.
  - `req` is ignored in the reset cycle.
- **Simultaneous events**
  - A switch and the owner's `req` dropping in the same cycle: the switch wins.
  - The new owner's color/level are captured in the switch cycle.

## Timing
- `req` rising in IDLE at edge t → `grant`/`busy` at t+1 → LED pins reflect the new color at t+2 (registered PWM output).
- Hold window: the owner is non-preemptible for exactly `HOLD_CYCLES` cycles from the grant edge. Earliest switch appears on `grant` `HOLD_CYCLES` edges after the previous grant.
- Color/level changes from the live owner reach the pins with 2-cycle latency.
- A PWM period is 2^`PWM_BITS` cycles: 256 cycles, 10.24 µs at 25 MHz.
- `grant` is always one-hot or zero, never multi-hot.

## Structure
- **Package `led_pkg`:**
  - state enum {IDLE, OWNED}
  - `LED_OFF`=1'b1
  - RGB bit-index constants `R_IDX`=2, `G_IDX`=1, `B_IDX`=0
- **Sub-module `led_pwm`:** `pwm_cnt`, compare, and registered active-low outputs. Parameterised by `PWM_BITS`; inputs latched color/level; outputs the three pins.
- Arbiter, hold counter and latches live in `rgb_led_arbiter`.

## Test plan
All scenarios use `HOLD_CYCLES`=8, `N_REQ`=3.
- **Reset values:** assert `rst` 3 cycles with `req`=3'b111 → `grant`=0, `busy`=0, LEDs=3'b111 throughout; first grant is 3'b001, one cycle after `rst` deasserts.
- **Priority in IDLE:** `req`=3'b110 in one cycle → `grant`=3'b010 next edge. With color1=3'b100 and level1=255, `led_r` is low for 255 of every 256 cycles and `led_g`/`led_b` stay 1.
- **Hold, no preemption:** grant requester 2, then raise `req[0]` one cycle later → `grant` stays 3'b100 for 8 cycles total, then 3'b001.
- **Short pulse visible:** 1-cycle `req[1]` pulse with color 3'b010, level 128 → `grant`=3'b010 for exactly 8 cycles, `led_g` duty 128/256 while owned, then IDLE with LEDs 3'b111.
- **Fall-through to lower:** owner 0 drops `req` after expiry while `req[2]` is high → `grant` goes 3'b001 → 3'b100 in one edge; `hold_cnt` reloads to 7.
- **Reset mid-hold and level 0:** `rst` at hold count 4 → outputs return to reset values next edge. Separately, an owner with `level`=0 keeps all LEDs at 1 for a full PWM period.
